// File: rtl/gray_step_decoder_pkg.sv
// Shared definitions for the gray step decoder slice.
// Holds the code width, the encoder's state codes, the decoder FSM state
// enumeration and the default lock threshold.
package gray_step_decoder_pkg;

  localparam int CODE_W       = 2;
  localparam int LOCK_CNT_DEF = 4;

  typedef logic [CODE_W-1:0] code_t;

  // Upstream step encoder state codes; it comes out of reset at ENC_S0.
  localparam code_t ENC_S0 = 2'b00;
  localparam code_t ENC_S1 = 2'b01;
  localparam code_t ENC_S2 = 2'b11;
  localparam code_t ENC_S3 = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TRACK,
    ST_LOCKED
  } gsd_state_e;

  // Exactly one flipped code bit is a legal step; bit 1 flipping encodes a 1.
  function automatic logic diff_legal(input code_t diff);
    return diff[1] ^ diff[0];
  endfunction

endpackage

// File: rtl/gray_step_decoder_byte_pack.sv
// gsd_byte_pack: assembles decoded bits LSB-first into bytes.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   bit_stb       a decoded bit is presented this cycle
//   bit_in        the decoded bit
//   clear         discard the partial byte (takes priority over bit_stb)
//   byte_valid    one-cycle pulse, registered alongside the 8th bit
//   byte_out      last completed byte, held until the next one completes
module gsd_byte_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_stb,
  input  logic       bit_in,
  input  logic       clear,
  output logic       byte_valid,
  output logic [7:0] byte_out
);

  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bit_stb) begin
      if (cnt_q == 3'd7) begin
        byte_out_d   = {bit_in, acc_q[6:0]};
        byte_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d[cnt_q] = bit_in;
        cnt_d        = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_out   = byte_out_q;

endmodule

// File: rtl/gray_step_decoder.sv
// gray_step_decoder: decodes a 2-bit step-code stream into bits and bytes.
// A single-bit change between consecutive accepted codes is a data bit
// (bit 0 flipping -> 0, bit 1 flipping -> 1); anything else is an error
// that drops the decoder back to HUNT.
// Ports:
//   clk, rst             clock and synchronous active-low reset
//   in_valid, in_code    sampled code from the upstream encoder
//   bit_valid, bit_out   decoded bit pulse (registered)
//   byte_valid, byte_out assembled byte, LSB-first
//   err, err_cnt         illegal-transition pulse and saturating count
//   locked               FSM is in LOCKED
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              locked
);

  localparam int LC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  gsd_state_e        state_q, state_d;
  code_t             prev_q, prev_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_out_q, bit_out_d;
  logic              err_q, err_d;
  logic              pack_clear;
  code_t             diff;

  assign diff = prev_q ^ in_code;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    lock_cnt_d  = lock_cnt_q;
    err_cnt_d   = err_cnt_q;
    bit_valid_d = 1'b0;
    bit_out_d   = 1'b0;
    err_d       = 1'b0;
    pack_clear  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          prev_d  = in_code;
          state_d = ST_TRACK;
        end
        ST_TRACK, ST_LOCKED: begin
          prev_d = in_code;
          if (diff_legal(diff)) begin
            bit_valid_d = 1'b1;
            bit_out_d   = diff[1];
            if (state_q == ST_TRACK) begin
              if (lock_cnt_q == LC_W'(LOCK_CNT - 1)) begin
                state_d    = ST_LOCKED;
                lock_cnt_d = '0;
              end else begin
                lock_cnt_d = lock_cnt_q + LC_W'(1);
              end
            end
          end else begin
            err_d      = 1'b1;
            pack_clear = 1'b1;
            lock_cnt_d = '0;
            state_d    = ST_HUNT;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_TRACK;
      prev_q      <= ENC_S0;
      lock_cnt_q  <= '0;
      err_cnt_q   <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      lock_cnt_q  <= lock_cnt_d;
      err_cnt_q   <= err_cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      err_q       <= err_d;
    end
  end

  // Fed the unregistered strobe so byte_valid lands with the 8th bit_valid.
  gsd_byte_pack u_byte_pack (
    .clk        (clk),
    .rst        (rst),
    .bit_stb    (bit_valid_d),
    .bit_in     (bit_out_d),
    .clear      (pack_clear),
    .byte_valid (byte_valid),
    .byte_out   (byte_out)
  );

  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule
